// File: rtl/vec_exec_pipe.sv
// Pipelined vector execute unit: per-lane ALU with optional unsigned saturation,
// followed by a STAGES-deep register pipe with valid/ready backpressure and flush.
module vec_exec_pipe #(
  parameter int LANES  = 8,
  parameter int EW     = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*EW-1:0]       srca,
  input  logic [LANES*EW-1:0]       srcb,
  input  logic [2:0]                alucontrol,
  input  logic                      scalar,
  input  logic                      sat,
  input  logic [TAG_W-1:0]          tag_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*EW-1:0]       result,
  output logic [LANES-1:0]          zero,
  output logic [LANES-1:0]          carry,
  output logic [TAG_W-1:0]          tag_out,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*TAG_W-1:0]   stage_tag
);

  localparam int SHW = (EW > 1) ? $clog2(EW) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MIN = 3'b111;

  // Returns {carry/borrow, raw lane value}; the top bit of a subtraction of
  // zero-extended operands is exactly the unsigned borrow.
  function automatic logic [EW:0] lane_alu(input logic [EW-1:0] a,
                                           input logic [EW-1:0] b,
                                           input logic [2:0]    op);
    logic [SHW-1:0] sh;
    logic [EW:0]    r;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SLL:  r = {1'b0, a << sh};
      OP_SRL:  r = {1'b0, a >> sh};
      default: r = {1'b0, (a < b) ? a : b};
    endcase
    return r;
  endfunction

  function automatic logic [EW-1:0] sat_lane(input logic [EW:0] r,
                                             input logic [2:0]  op,
                                             input logic        sat_en);
    logic [EW-1:0] v;
    v = r[EW-1:0];
    if (sat_en && r[EW] && (op == OP_ADD)) v = '1;
    if (sat_en && r[EW] && (op == OP_SUB)) v = '0;
    return v;
  endfunction

  logic [LANES*EW-1:0] res_d;
  logic [LANES-1:0]    zero_d;
  logic [LANES-1:0]    carry_d;
  logic [EW-1:0]       lane_b;
  logic [EW:0]         lane_raw;
  logic [EW-1:0]       lane_val;

  always_comb begin
    res_d    = '0;
    zero_d   = '0;
    carry_d  = '0;
    lane_b   = '0;
    lane_raw = '0;
    lane_val = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_b   = scalar ? srcb[EW-1:0] : srcb[i*EW +: EW];
      lane_raw = lane_alu(srca[i*EW +: EW], lane_b, alucontrol);
      lane_val = sat_lane(lane_raw, alucontrol, sat);
      res_d[i*EW +: EW] = lane_val;
      carry_d[i]        = lane_raw[EW];
      zero_d[i]         = (lane_val == '0);
    end
  end

  logic                vld_q   [STAGES];
  logic [LANES*EW-1:0] res_q   [STAGES];
  logic [LANES-1:0]    zero_q  [STAGES];
  logic [LANES-1:0]    carry_q [STAGES];
  logic [TAG_W-1:0]    tag_q   [STAGES];

  logic stall;
  logic accept;

  assign stall    = vld_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Stage boundaries: stage 0 captures the ALU output, later stages shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]   <= 1'b0;
        res_q[s]   <= '0;
        zero_q[s]  <= '0;
        carry_q[s] <= '0;
        tag_q[s]   <= '0;
      end
    end else begin
      if (flush) begin
        for (int s = 0; s < STAGES; s++) vld_q[s] <= 1'b0;
      end else if (!stall) begin
        vld_q[0] <= accept;
        for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
      end
      if (!stall) begin
        if (accept) begin
          res_q[0]   <= res_d;
          zero_q[0]  <= zero_d;
          carry_q[0] <= carry_d;
          tag_q[0]   <= tag_in;
        end
        for (int s = 1; s < STAGES; s++) begin
          res_q[s]   <= res_q[s-1];
          zero_q[s]  <= zero_q[s-1];
          carry_q[s] <= carry_q[s-1];
          tag_q[s]   <= tag_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign zero      = zero_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];

  always_comb begin
    stage_valid = '0;
    stage_tag   = '0;
    for (int s = 0; s < STAGES; s++) begin
      stage_valid[s]                = vld_q[s];
      stage_tag[s*TAG_W +: TAG_W]   = tag_q[s];
    end
  end

endmodule
